fifo_rd_port: RTL and testbench

//  Read-side controller of the async FIFO, living entirely in the read clock domain.

---
 rtl/fifo_rd_port_pkg.sv | 27 ++
 rtl/fifo_rd_port_if.sv | 44 ++++
 rtl/fifo_rd_port_ptr_sync.sv | 30 +++
 rtl/fifo_rd_port.sv | 101 ++++++++++
 tb/tb_fifo_rd_port.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_port_pkg.sv
// Shared definitions for the async FIFO pointer logic: Gray/binary helpers
// (also used by the write-side controller) and the read output-stage state type.
package fifo_rd_port_pkg;

    // Helpers work at this width; callers zero-extend and truncate to their pointer width.
    localparam int PTR_MAX_W = 32;

    typedef enum logic [0:0] {
        OS_EMPTY = 1'b0,
        OS_FULL  = 1'b1
    } out_state_t;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros from zero-extension decode to zeros, so narrower pointers convert exactly.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_port_if.sv
// Read-side bundle of the async FIFO: write-pointer/memory inputs, read pointer
// status and the consumer-facing output stage.
interface fifo_rd_port_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] wptr_gray;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-2:0] raddr;
    logic [ADDR_WIDTH-1:0] rptr_gray;
    logic                  rempty;
    logic [ADDR_WIDTH-1:0] rd_level;

    // Handshake: a word moves when rd_valid && rd_ready at a rising rclk edge.
    // rd_data is stable while rd_valid && !rd_ready; rd_ready with rd_valid=0 is ignored.
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    modport master (
        input  wptr_gray,
        input  mem_rdata,
        input  rd_ready,
        output raddr,
        output rptr_gray,
        output rempty,
        output rd_level,
        output rd_data,
        output rd_valid
    );

    modport slave (
        output wptr_gray,
        output mem_rdata,
        output rd_ready,
        input  raddr,
        input  rptr_gray,
        input  rempty,
        input  rd_level,
        input  rd_data,
        input  rd_valid
    );

endinterface

// File: rtl/fifo_rd_port_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// Reused by the write side for the read pointer.
module fifo_rd_port_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_port.sv
// Read-domain controller of the async FIFO: write-pointer sync, empty flag,
// read address and a one-entry registered valid/ready output stage.
module fifo_rd_port
    import fifo_rd_port_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    fifo_rd_port_if.master      bus,
    output out_state_t          dbg_state
);

    logic [ADDR_WIDTH-1:0] wq_gray;
    logic [ADDR_WIDTH-1:0] wq_bin;
    logic [ADDR_WIDTH-1:0] rbin;
    logic [ADDR_WIDTH-1:0] rbin_next;
    logic [ADDR_WIDTH-1:0] rgray_next;
    logic [ADDR_WIDTH-1:0] rptr_gray_q;
    logic                  rempty_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  pop;
    out_state_t            state_q;
    out_state_t            state_d;

    fifo_rd_port_ptr_sync #(
        .WIDTH  (ADDR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (bus.wptr_gray),
        .q     (wq_gray)
    );

    assign wq_bin = ADDR_WIDTH'(gray2bin(PTR_MAX_W'(wq_gray)));

    // A memory word is fetched whenever one is available and the output stage is free or draining.
    always_comb begin
        pop        = !rempty_q && ((state_q == OS_EMPTY) || bus.rd_ready);
        rbin_next  = rbin + {{(ADDR_WIDTH-1){1'b0}}, pop};
        rgray_next = ADDR_WIDTH'(bin2gray(PTR_MAX_W'(rbin_next)));
    end

    // Empty compares the full pointer including the wrap bit; an MSB-only difference means full.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin        <= '0;
            rptr_gray_q <= '0;
            rempty_q    <= 1'b1;
        end else begin
            rbin        <= rbin_next;
            rptr_gray_q <= rgray_next;
            rempty_q    <= (rgray_next == wq_gray);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_data_q <= '0;
        end else if (pop) begin
            rd_data_q <= bus.mem_rdata;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= OS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OS_EMPTY: begin
                if (pop) state_d = OS_FULL;
            end
            OS_FULL: begin
                // Consume with a simultaneous pop keeps the stage full for back-to-back words.
                if (bus.rd_ready && !pop) state_d = OS_EMPTY;
            end
            default: state_d = OS_EMPTY;
        endcase
    end

    always_comb begin
        bus.rd_valid = (state_q == OS_FULL);
        dbg_state    = state_q;
    end

    assign bus.raddr     = rbin[ADDR_WIDTH-2:0];
    assign bus.rptr_gray = rptr_gray_q;
    assign bus.rempty    = rempty_q;
    assign bus.rd_level  = wq_bin - rbin;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Bench for fifo_rd_port: hand-computed vector table, directed wrap/stream/reset
// sequences and randomized traffic against a word-count reference model.
module tb_fifo_rd_port;
    import fifo_rd_port_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int SYNC = 2;

    logic       rclk = 1'b0;
    logic       rrst_n;
    out_state_t dbg_state;

    fifo_rd_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_rd_port #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 rclk = ~rclk;

    // Memory model with a combinational read port.
    logic [DW-1:0] mem [8];
    assign bus.mem_rdata = mem[bus.raddr];

    int n_vec = 0;
    int n_err = 0;

    // Writer / consumer bookkeeping and scoreboard.
    int            wcount;
    int            ccount;
    logic [DW-1:0] exp_q[$];

    // Reference model: words counted, not pointers decoded.
    bit            valid_m;
    bit            empty_m;
    logic [DW-1:0] data_m;
    logic [3:0]    rcount;
    logic [3:0]    wq_m;
    logic [3:0]    hist[$];

    typedef struct {
        bit         do_reset;
        int         nwr;
        logic [7:0] wd;
        bit         rdy;
        bit         e_empty;
        bit         e_valid;
        logic [7:0] e_data;
        logic [2:0] e_raddr;
        logic [3:0] e_rptr;
        logic [3:0] e_level;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        wcount  = 0;
        ccount  = 0;
        exp_q.delete();
        valid_m = 1'b0;
        empty_m = 1'b1;
        data_m  = '0;
        rcount  = '0;
        wq_m    = '0;
        hist.delete();
        bus.wptr_gray = '0;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        rrst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    task automatic compare_all();
        check("rempty",    bus.rempty,    empty_m);
        check("rd_valid",  bus.rd_valid,  valid_m);
        check("rd_data",   bus.rd_data,   data_m);
        check("raddr",     bus.raddr,     rcount[2:0]);
        check("rptr_gray", bus.rptr_gray, g4(rcount));
        check("rd_level",  bus.rd_level,  4'(wq_m - rcount));
        check("dbg_state", dbg_state,     valid_m ? OS_FULL : OS_EMPTY);
    endtask

    // One rclk cycle: drive inputs, score consumption, advance the model, compare after the edge.
    task automatic step(input int nwr, input logic [7:0] wd, input bit rdy);
        logic [3:0] wq_prev;
        bit         pop_m;
        for (int i = 0; i < nwr; i++) begin
            if (wcount - ccount < 8) begin
                mem[wcount % 8] = 8'(wd + 8'(i));
                exp_q.push_back(8'(wd + 8'(i)));
                wcount++;
            end
        end
        bus.wptr_gray = g4(4'(wcount));
        bus.rd_ready  = rdy;
        if (bus.rd_valid && rdy) begin
            ccount++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got word %0h with none expected", bus.rd_data);
            end else begin
                check("sb_order", bus.rd_data, exp_q.pop_front());
            end
        end
        wq_prev = wq_m;
        pop_m   = !empty_m && (!valid_m || rdy);
        if (pop_m) begin
            data_m  = mem[rcount[2:0]];
            valid_m = 1'b1;
            rcount  = rcount + 4'd1;
        end else if (valid_m && rdy) begin
            valid_m = 1'b0;
        end
        empty_m = (rcount == wq_prev);
        hist.push_back(4'(wcount));
        if (hist.size() > SYNC) void'(hist.pop_front());
        wq_m = (hist.size() == SYNC) ? hist[0] : 4'd0;
        @(posedge rclk);
        #1;
        compare_all();
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            step(0, 8'h00, 1'b1);
            guard++;
        end
        step(0, 8'h00, 1'b1);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int vcnt;
        rrst_n = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        reset_model();

        // Reset state with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            bus.wptr_gray = 4'($urandom);
            bus.rd_ready  = 1'($urandom);
            @(posedge rclk);
            #1;
            check("rst_rempty",    bus.rempty,    1);
            check("rst_rd_valid",  bus.rd_valid,  0);
            check("rst_raddr",     bus.raddr,     0);
            check("rst_rptr_gray", bus.rptr_gray, 0);
            check("rst_rd_level",  bus.rd_level,  0);
            check("rst_rd_data",   bus.rd_data,   0);
        end
        reset_model();
        rrst_n = 1'b1;

        // Single word (rows 0-4) and backpressure (rows 5-13), expected values by hand.
        //            rst nwr  wd     rdy  empty valid data  raddr rptr level
        tbl[0]  = '{1, 1, 8'hA5, 1,   1, 0, 8'h00, 0, 4'h0, 4'd0};
        tbl[1]  = '{0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 4'h0, 4'd1};
        tbl[2]  = '{0, 0, 8'h00, 1,   0, 0, 8'h00, 0, 4'h0, 4'd1};
        tbl[3]  = '{0, 0, 8'h00, 1,   1, 1, 8'hA5, 1, 4'h1, 4'd0};
        tbl[4]  = '{0, 0, 8'h00, 1,   1, 0, 8'hA5, 1, 4'h1, 4'd0};
        tbl[5]  = '{1, 3, 8'h11, 0,   1, 0, 8'h00, 0, 4'h0, 4'd0};
        tbl[6]  = '{0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 4'h0, 4'd3};
        tbl[7]  = '{0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 4'h0, 4'd3};
        tbl[8]  = '{0, 0, 8'h00, 0,   0, 1, 8'h11, 1, 4'h1, 4'd2};
        tbl[9]  = '{0, 0, 8'h00, 0,   0, 1, 8'h11, 1, 4'h1, 4'd2};
        tbl[10] = '{0, 0, 8'h00, 0,   0, 1, 8'h11, 1, 4'h1, 4'd2};
        tbl[11] = '{0, 0, 8'h00, 1,   0, 1, 8'h12, 2, 4'h3, 4'd1};
        tbl[12] = '{0, 0, 8'h00, 1,   1, 1, 8'h13, 3, 4'h2, 4'd0};
        tbl[13] = '{0, 0, 8'h00, 1,   1, 0, 8'h13, 3, 4'h2, 4'd0};
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].do_reset) apply_reset();
            step(tbl[i].nwr, tbl[i].wd, tbl[i].rdy);
            check($sformatf("tbl%0d_rempty", i),    bus.rempty,    tbl[i].e_empty);
            check($sformatf("tbl%0d_rd_valid", i),  bus.rd_valid,  tbl[i].e_valid);
            check($sformatf("tbl%0d_rd_data", i),   bus.rd_data,   tbl[i].e_data);
            check($sformatf("tbl%0d_raddr", i),     bus.raddr,     tbl[i].e_raddr);
            check($sformatf("tbl%0d_rptr_gray", i), bus.rptr_gray, tbl[i].e_rptr);
            check($sformatf("tbl%0d_rd_level", i),  bus.rd_level,  tbl[i].e_level);
        end

        // Wrap: 16 words round the pointer back to zero, then 8 more with the consumer stalled.
        apply_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + 8'(i)), 1'b1);
        drain();
        check("wrap_rptr_zero",  bus.rptr_gray, 0);
        check("wrap_raddr_zero", bus.raddr,     0);
        step(8, 8'h80, 1'b0);
        step(0, 8'h00, 1'b0);
        check("wrap_level_synced", bus.rd_level, 8);
        step(0, 8'h00, 1'b0);
        check("wrap_not_empty", bus.rempty,   0);
        check("wrap_level",     bus.rd_level, 8);
        drain();
        for (int i = 0; i < 4; i++) step(1, 8'(8'hE0 + 8'(i)), 1'b1);
        drain();

        // Continuous stream: the output stage must stay full once running.
        apply_reset();
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(i + 1), 1'b1);
            if (i >= 9 && bus.rd_valid) vcnt++;
        end
        check("stream_valid_cycles", vcnt, 31);
        for (int i = 0; i < 40; i++) step(1, 8'($urandom), (i % 2) == 0);
        drain();

        // Reset mid-stream with a word held and three still in memory.
        apply_reset();
        step(4, 8'hC0, 1'b0);
        repeat (3) step(0, 8'h00, 1'b0);
        check("mid_pre_valid", bus.rd_valid, 1);
        check("mid_pre_level", bus.rd_level, 3);
        rrst_n = 1'b0;
        #2;
        check("mid_rempty",    bus.rempty,    1);
        check("mid_rd_valid",  bus.rd_valid,  0);
        check("mid_rd_data",   bus.rd_data,   0);
        check("mid_raddr",     bus.raddr,     0);
        check("mid_rptr_gray", bus.rptr_gray, 0);
        check("mid_rd_level",  bus.rd_level,  0);
        reset_model();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, 1'b1);
            check("mid_stays_empty", bus.rempty, 1);
        end

        // Randomized traffic and backpressure.
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            int nwr;
            nwr = ($urandom_range(0, 99) < 55) ? 1 : 0;
            if ($urandom_range(0, 19) == 0) nwr = $urandom_range(2, 5);
            step(nwr, 8'($urandom), ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
